// File: rtl/dm_unit_if.sv
// Bus bundle between the ALU/GRF side of the datapath and the data-memory stage.
interface dm_unit_if;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [2:0]  mem_op;
  logic        load_sign;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] wr_count;

  modport master (
    output pc, addr, wdata, mem_write, mem_op, load_sign,
    input  rdata, addr_err, wr_count
  );

  modport slave (
    input  pc, addr, wdata, mem_write, mem_op, load_sign,
    output rdata, addr_err, wr_count
  );
endinterface

// File: rtl/dm_unit.sv
// Data-memory stage: byte-addressed little-endian word array with sized loads/stores.
// Optional store trace line enabled by defining DM_TRACE_EN.
module dm_unit #(
  parameter int          DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  dm_unit_if.slave  bus
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HALF = 3'b001;
  localparam logic [2:0] OP_BYTE = 3'b010;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          err;
  logic          we;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic [31:0]   rd_val;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   count_q;

  assign off  = bus.addr - BASE_ADDR;
  assign lane = off[1:0];
  assign idx  = off[AW+1:2];

  always_comb begin
    err = 1'b0;
    if (off >= LIMIT) err = 1'b1;
    case (bus.mem_op)
      OP_WORD: if (lane != 2'b00) err = 1'b1;
      OP_HALF: if (lane[0]) err = 1'b1;
      OP_BYTE: ;
      default: err = 1'b1;
    endcase
  end

  assign we  = bus.mem_write && !err;
  // Out-of-range indices never reach the array value path.
  assign cur = err ? 32'h0 : mem[idx];

  always_comb begin
    merged = cur;
    case (bus.mem_op)
      OP_WORD: merged = bus.wdata;
      OP_HALF: begin
        if (lane[1]) merged[31:16] = bus.wdata[15:0];
        else         merged[15:0]  = bus.wdata[15:0];
      end
      OP_BYTE: merged[{lane, 3'b000} +: 8] = bus.wdata[7:0];
      default: merged = cur;
    endcase
  end

  assign half_sel = lane[1] ? cur[31:16] : cur[15:0];
  assign byte_sel = cur[{lane, 3'b000} +: 8];

  always_comb begin
    rd_val = 32'h0;
    case (bus.mem_op)
      OP_WORD: rd_val = cur;
      OP_HALF: rd_val = {{16{bus.load_sign & half_sel[15]}}, half_sel};
      OP_BYTE: rd_val = {{24{bus.load_sign & byte_sel[7]}}, byte_sel};
      default: rd_val = 32'h0;
    endcase
  end

  assign bus.rdata    = err ? 32'h0 : rd_val;
  assign bus.addr_err = err;
  assign bus.wr_count = count_q;

  // One register process per word keeps the async clear free of array loops.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     mem[g] <= 32'h0;
      else if (we && idx == AW'(g))   mem[g] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  count_q <= 32'h0;
    else if (we) count_q <= count_q + 32'h1;
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && we)
      $display("@%08h: *%08h <= %08h", bus.pc, BASE_ADDR + {off[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory stage of the single-cycle MIPS datapath, directly downstream of the ALU.
- Consumes the ALU result as a byte address and the GRF rt value as store data.
- Performs word/half/byte stores with byte-lane merging, and word/half/byte loads with sign or zero extension.
- Read data feeds the GRF write-back mux.

Parameters:
- DEPTH, 3072, number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- pc  input  32  PC of the instruction in this stage (trace only)
- addr  input  32  byte address (ALU result)
- wdata  input  32  store data (rt)
- mem_write  input  1  store strobe for this cycle
- mem_op  input  3  access size: 000 word, 001 half, 010 byte; all other codes illegal
- load_sign  input  1  1 = sign-extend half/byte loads, 0 = zero-extend
- rdata  output  32  extended load data
- addr_err  output  1  illegal or misaligned access this cycle
- wr_count  output  32  number of committed stores

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low: reset low immediately clears every memory word and wr_count to 0.
- Address decode: off = addr - BASE_ADDR; word index = off[31:2]; lane = off[1:0]. Memory is little-endian; byte k occupies bits [8k+7:8k].
- addr_err (combinational) is 1 when any of these holds:
  - off >= DEPTH*4
  - mem_op is word and lane != 0
  - mem_op is half and lane[0] = 1
  - mem_op is an illegal code
- addr_err is evaluated regardless of mem_write.
- Reads are combinational, zero latency. rdata is valid in the same cycle as addr.
  - word: the full word.
  - half: bits [15:0] for lane 0, bits [31:16] for lane 2; extended per load_sign.
  - byte: the selected lane; extended per load_sign.
  - addr_err = 1 forces rdata = 0.
- Stores commit on the rising clk edge when mem_write = 1, addr_err = 0 and reset = 1.
  - word: replaces the whole word.
  - half: wdata[15:0] goes into the addressed halfword; the other half is unchanged.
  - byte: wdata[7:0] goes into the addressed lane; the other lanes are unchanged.
- A store with addr_err = 1 is dropped. Memory and wr_count are unchanged; no other side effect.
- wr_count increments by 1 per committed store and wraps from 32'hFFFF_FFFF to 0.
- Read during write to the same word: rdata shows the pre-edge contents until the edge, then the merged value.
- Reset asserted mid-cycle or coincident with a store edge: reset wins. The store is lost, the array is all zero, and wr_count = 0.
- While reset is low, stores are ignored and rdata reads 0 for legal addresses.
- Reset values: rdata = 0 (array cleared), wr_count = 0. addr_err follows the inputs combinationally.

Optional Feature:
- Macro: DM_TRACE_EN.
- When defined, every committed store executes one display line of the form "@<pc hex8>: *<word byte-address hex8> <= <merged full word hex8>". The word byte-address is BASE_ADDR + index*4. The line prints at the committing edge, exactly once per store; dropped stores print nothing.
- When undefined, no display statements are compiled, pc is unused, and all other behaviour is identical.

Test Plan:
- Word store and load: reset pulse low; sw addr=0x10, wdata=0x12345678, one edge -> lw addr=0x10 gives rdata=0x12345678, wr_count=1.
- Byte merge: after the above, sb addr=0x11, wdata=0xAB -> lw 0x10 = 0x1234AB78; lb 0x11 signed = 0xFFFFFFAB; lbu 0x11 = 0x000000AB.
- Half merge: sh addr=0x12, wdata=0x00008001 -> lw 0x10 = 0x8001AB78; lh 0x12 = 0xFFFF8001; lhu 0x12 = 0x00008001.
- Misalignment and range: sw 0x13 -> addr_err=1, memory and wr_count unchanged; lh 0x11 -> addr_err=1, rdata=0; lw 0x3000 (DEPTH=3072) -> addr_err=1; mem_op=3'b111 -> addr_err=1.
- Asynchronous reset mid-operation: store pending with mem_write=1, reset dropped low between edges -> rdata=0 and wr_count=0 immediately; the next edge with reset low commits nothing.
- Trace (DM_TRACE_EN defined): pc=0x00003000, sb addr=0x11, wdata=0xAB onto word 0x12345678 -> exactly one line "@00003000: *00000010 <= 1234ab78"; a misaligned sw prints no line.
